fp_output_stage: RTL

FP_OUTPUT_STAGE -- requirements
Module: fp_output_stage

---
 rtl/fp_output_stage.sv | 96 +++++++++
 1 files changed

// File: rtl/fp_output_stage.sv
// DES final permutation (IP^-1) with a small valid/ready output FIFO.
// Optional delivered-block counter on blk_cnt when FP_BLK_CNT_EN is defined.
module fp_output_stage #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] l16,
  input  logic [31:0] r16,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] des_out
`ifdef FP_BLK_CNT_EN
  ,
  output logic [15:0] blk_cnt
`endif
);

  // Handshake: a transfer happens on a rising edge where valid && ready;
  // valid never waits on ready, and ready here depends only on registered state.

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(FIFO_DEPTH - 1);

  // Entry i (DES numbering, 1 = MSB) of the output takes preoutput bit FP[i].
  localparam int FP [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41,  9, 49, 17, 57, 25
  };

  logic [63:0]   preoutput;
  logic [63:0]   perm;
  logic [63:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;

  assign preoutput = {r16, l16};

  for (genvar i = 0; i < 64; i++) begin : g_fp
    assign perm[63-i] = preoutput[64-FP[i]];
  end

  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign des_out   = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        mem[k] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= perm;
        wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef FP_BLK_CNT_EN
  // Free-running 16-bit wrap is intended.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_cnt <= '0;
    end else if (pop) begin
      blk_cnt <= blk_cnt + 16'd1;
    end
  end
`endif

endmodule
